// File: rtl/table_access_arbiter_if.sv
// Lane request/response and table-port bundle for the table access arbiter.
// master = lanes plus table (the environment); slave = the arbiter itself.
interface table_access_arbiter_if #(
  parameter int lane_num = 2,
  parameter int pkt_w    = 33
);
  logic [lane_num-1:0]       lane_req_valid;
  logic [lane_num-1:0]       lane_req_ready;
  logic [lane_num*pkt_w-1:0] lane_req_pkt;
  logic                      table_ex_ready_i;
  logic                      table_ex_valid_i;
  logic [pkt_w-1:0]          table_ex_pkt_i;
  logic                      table_ex_valid_o;
  logic [pkt_w-1:0]          table_ex_pkt_o;
  logic                      table_ex_ready_o;
  logic [lane_num-1:0]       lane_rsp_valid;
  logic [lane_num-1:0]       lane_rsp_ready;
  logic [pkt_w-1:0]          lane_rsp_pkt;
  logic                      err_orphan;

  modport master (
    output lane_req_valid, lane_req_pkt, table_ex_ready_i,
    output table_ex_valid_o, table_ex_pkt_o, lane_rsp_ready,
    input  lane_req_ready, table_ex_valid_i, table_ex_pkt_i,
    input  table_ex_ready_o, lane_rsp_valid, lane_rsp_pkt, err_orphan
  );

  modport slave (
    input  lane_req_valid, lane_req_pkt, table_ex_ready_i,
    input  table_ex_valid_o, table_ex_pkt_o, lane_rsp_ready,
    output lane_req_ready, table_ex_valid_i, table_ex_pkt_i,
    output table_ex_ready_o, lane_rsp_valid, lane_rsp_pkt, err_orphan
  );
endinterface

// File: rtl/table_access_arbiter.sv
// Round-robin share of one table port among lanes; in-order tag FIFO steers responses back. TABLE_ARB_STATS_EN adds counters.
// Zero-latency grant and response steering; issue stalls when table not ready or max_outstanding in flight.
module table_access_arbiter #(
  parameter int lane_num        = 2,
  parameter int info_length     = 20,
  parameter int order_id        = 3,
  parameter int register_num    = 32,
  parameter int rob_num         = 16,
  parameter int max_outstanding = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  table_access_arbiter_if.slave bus
`ifdef TABLE_ARB_STATS_EN
  ,
  output logic [lane_num*16-1:0] grant_cnt,
  output logic [15:0]            stall_cnt
`endif
);
  localparam int register_width = $clog2(register_num);
  localparam int rob_width      = $clog2(rob_num);
  localparam int lane_width     = (lane_num > 1) ? $clog2(lane_num) : 1;
  localparam int pkt_w          = info_length + order_id + 1 + register_width + rob_width;
  localparam int ptr_w          = $clog2(max_outstanding);
  localparam int cnt_w          = ptr_w + 1;

  logic [lane_width-1:0] rr_ptr;
  logic [lane_width-1:0] tags [max_outstanding];
  logic [ptr_w-1:0]      wr_ptr;
  logic [ptr_w-1:0]      rd_ptr;
  logic [cnt_w-1:0]      count;
  logic                  err_q;

  logic                  can_issue;
  logic                  empty;
  logic [lane_width-1:0] head;
  logic                  pop;
  logic [lane_num-1:0]   grant;
  logic [lane_width-1:0] grant_idx;
  logic [lane_width-1:0] scan_idx;
  logic                  found;
  logic [pkt_w-1:0]      req_pkt [lane_num];

  // rst gates every handshake output so they drop the instant reset asserts.
  assign can_issue = rst && bus.table_ex_ready_i && (count < cnt_w'(max_outstanding));
  assign empty     = (count == '0);
  assign head      = tags[rd_ptr];

  always_comb begin
    for (int i = 0; i < lane_num; i++) begin
      req_pkt[i] = bus.lane_req_pkt[i*pkt_w +: pkt_w];
    end
  end

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    scan_idx  = '0;
    for (int i = 0; i < lane_num; i++) begin
      scan_idx = lane_width'((int'(rr_ptr) + i) % lane_num);
      if (can_issue && !found && bus.lane_req_valid[scan_idx]) begin
        grant[scan_idx] = 1'b1;
        grant_idx       = scan_idx;
        found           = 1'b1;
      end
    end
  end

  assign bus.lane_req_ready   = grant;
  assign bus.table_ex_valid_i = found;
  assign bus.table_ex_pkt_i   = found ? req_pkt[grant_idx] : '0;

  assign bus.lane_rsp_valid   = (rst && !empty && bus.table_ex_valid_o) ? (lane_num'(1) << head) : '0;
  assign bus.table_ex_ready_o = rst && !empty && bus.lane_rsp_ready[head];
  assign bus.lane_rsp_pkt     = bus.table_ex_pkt_o;
  assign bus.err_orphan       = err_q;
  assign pop                  = bus.table_ex_valid_o && bus.table_ex_ready_o;

  always_ff @(posedge clk) begin
    if (found) begin
      tags[wr_ptr] <= grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (found) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (int'(grant_idx) == lane_num - 1) ? '0 : grant_idx + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (found && !pop) begin
        count <= count + 1'b1;
      end else if (!found && pop) begin
        count <= count - 1'b1;
      end
      // A response with nothing in flight means the table and arbiter lost sync.
      if (empty && bus.table_ex_valid_o) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef TABLE_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < lane_num; i++) begin
        if (grant[i] && grant_cnt[i*16 +: 16] != 16'hFFFF) begin
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
        end
      end
      if (|bus.lane_req_valid && !can_issue && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_table_access_arbiter.sv
// Randomised plus directed bench for table_access_arbiter; queue-based reference model feeds a scoreboard.
module tb_table_access_arbiter;
  localparam int L    = 2;
  localparam int PW   = 33;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  table_access_arbiter_if #(.lane_num(L), .pkt_w(PW)) bus();

`ifdef TABLE_ARB_STATS_EN
  logic [L*16-1:0] grant_cnt;
  logic [15:0]     stall_cnt;
`endif

  table_access_arbiter #(.lane_num(L), .max_outstanding(MAXO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef TABLE_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct {
    int            cyc;
    logic [L-1:0]  oh;
    logic [PW-1:0] pkt;
  } ev_t;

  typedef struct {
    logic [L-1:0]  req_rdy;
    logic          tvi;
    logic          tro;
    logic [L-1:0]  rsp_vld;
    logic [PW-1:0] rsp_pkt;
    logic          err;
  } st_t;

  ev_t iss_q[$];
  ev_t rsp_q[$];
  st_t st_q[$];

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  // Reference model: lookups in flight as a plain queue of lane numbers.
  int m_tags[$];
  int m_rr  = 0;
  bit m_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    tests++;
    fails++;
    $display("FAIL %s at cycle %0d: DUT output with no expected entry", nm, cyc);
  endtask

  function automatic logic bit_of(input logic [L-1:0] v, input int idx);
    return ((v >> idx) & L'(1)) != '0;
  endfunction

  task automatic step(input logic r, input logic [L-1:0] rv, input logic tr,
                      input logic tv, input logic [L-1:0] rdy);
    logic [L*PW-1:0] pk;
    logic [PW-1:0]   lp [L];
    logic [PW-1:0]   tp;
    st_t s;
    ev_t e;
    int  g;
    bit  was_empty;
    bit  popd;
    @(posedge clk);
    #1;
    for (int i = 0; i < L; i++) begin
      lp[i] = PW'({$urandom(), $urandom()});
      pk[i*PW +: PW] = lp[i];
    end
    tp = PW'({$urandom(), $urandom()});
    rst                  = r;
    bus.lane_req_valid   = rv;
    bus.lane_req_pkt     = pk;
    bus.table_ex_ready_i = tr;
    bus.table_ex_valid_o = tv;
    bus.table_ex_pkt_o   = tp;
    bus.lane_rsp_ready   = rdy;

    s.req_rdy = '0;
    s.tvi     = 1'b0;
    s.tro     = 1'b0;
    s.rsp_vld = '0;
    s.rsp_pkt = tp;
    if (!r) begin
      m_tags.delete();
      m_rr  = 0;
      m_err = 1'b0;
      s.err = 1'b0;
      st_q.push_back(s);
      return;
    end
    s.err = m_err;

    g = -1;
    if (tr && m_tags.size() < MAXO) begin
      for (int i = 0; i < L; i++) begin
        if (g < 0 && bit_of(rv, (m_rr + i) % L)) g = (m_rr + i) % L;
      end
    end
    if (g >= 0) begin
      s.req_rdy = L'(1) << g;
      s.tvi     = 1'b1;
      e.cyc = cyc;
      e.oh  = s.req_rdy;
      e.pkt = lp[g];
      iss_q.push_back(e);
    end

    was_empty = (m_tags.size() == 0);
    popd      = 1'b0;
    if (!was_empty) begin
      s.tro = bit_of(rdy, m_tags[0]);
      if (tv) begin
        s.rsp_vld = L'(1) << m_tags[0];
        e.cyc = cyc;
        e.oh  = s.rsp_vld;
        e.pkt = tp;
        rsp_q.push_back(e);
        popd = s.tro;
      end
    end
    st_q.push_back(s);

    if (popd) void'(m_tags.pop_front());
    if (g >= 0) begin
      m_tags.push_back(g);
      m_rr = (g + 1) % L;
    end
    if (was_empty && tv) m_err = 1'b1;
  endtask

  task automatic rnd_step(input logic r);
    logic tv;
    tv = (m_tags.size() > 0) && ($urandom_range(1, 0) == 1);
    step(r, L'($urandom()), ($urandom_range(3, 0) != 0), tv, L'($urandom()));
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * MAXO && m_tags.size() > 0; i++) begin
      step(1'b1, '0, 1'b1, 1'b1, '1);
    end
  endtask

  // Monitor: per-cycle status plus issue/response events whenever the DUT presents them.
  initial begin : monitor
    st_t s;
    ev_t e;
    forever begin
      @(negedge clk);
      if (st_q.size() > 0) begin
        s = st_q.pop_front();
        check("lane_req_ready",   64'(bus.lane_req_ready),   64'(s.req_rdy));
        check("table_ex_valid_i", 64'(bus.table_ex_valid_i), 64'(s.tvi));
        check("table_ex_ready_o", 64'(bus.table_ex_ready_o), 64'(s.tro));
        check("lane_rsp_valid",   64'(bus.lane_rsp_valid),   64'(s.rsp_vld));
        check("lane_rsp_pkt",     64'(bus.lane_rsp_pkt),     64'(s.rsp_pkt));
        check("err_orphan",       64'(bus.err_orphan),       64'(s.err));
      end
      if (bus.table_ex_valid_i) begin
        if (iss_q.size() == 0) miss("issue_extra");
        else begin
          e = iss_q.pop_front();
          check("issue_cycle", 64'(cyc), 64'(e.cyc));
          check("issue_lane",  64'(bus.lane_req_ready), 64'(e.oh));
          check("issue_pkt",   64'(bus.table_ex_pkt_i), 64'(e.pkt));
        end
      end else begin
        check("issue_idle_pkt", 64'(bus.table_ex_pkt_i), 64'(0));
      end
      if (bus.lane_rsp_valid != '0) begin
        if (rsp_q.size() == 0) miss("rsp_extra");
        else begin
          e = rsp_q.pop_front();
          check("rsp_cycle", 64'(cyc), 64'(e.cyc));
          check("rsp_lane",  64'(bus.lane_rsp_valid), 64'(e.oh));
          check("rsp_pkt",   64'(bus.lane_rsp_pkt), 64'(e.pkt));
        end
      end
    end
  end

  initial begin
    bus.lane_req_valid   = '0;
    bus.lane_req_pkt     = '0;
    bus.table_ex_ready_i = 1'b0;
    bus.table_ex_valid_o = 1'b0;
    bus.table_ex_pkt_o   = '0;
    bus.lane_rsp_ready   = '0;

    repeat (2) step(1'b0, 2'b11, 1'b1, 1'b0, 2'b11);

    // Fill: alternating grants until four are in flight, then a blocked cycle.
    repeat (5) step(1'b1, 2'b11, 1'b1, 1'b0, 2'b00);
    // Pop while full, then the freed slot is granted.
    step(1'b1, 2'b11, 1'b1, 1'b1, 2'b11);
    step(1'b1, 2'b10, 1'b1, 1'b0, 2'b00);
    drain();

    // Head lane not ready: response stalls even though the other lane is.
    step(1'b1, 2'b01, 1'b1, 1'b0, 2'b00);
    step(1'b1, 2'b10, 1'b1, 1'b0, 2'b00);
    repeat (3) step(1'b1, 2'b00, 1'b1, 1'b1, 2'b10);
    repeat (2) step(1'b1, 2'b00, 1'b1, 1'b1, 2'b11);

    // Three in flight, then simultaneous push and pop across pointer wrap.
    repeat (3) step(1'b1, 2'b11, 1'b1, 1'b0, 2'b00);
    repeat (6) step(1'b1, 2'b11, 1'b1, 1'b1, 2'b11);
    drain();

    // Orphan response sets the sticky error.
    step(1'b1, 2'b00, 1'b1, 1'b1, 2'b11);
    repeat (2) step(1'b1, 2'b00, 1'b1, 1'b0, 2'b00);

    repeat (400) rnd_step(1'b1);

    // Reset mid-traffic, then lane 0 must win first.
    repeat (2) rnd_step(1'b0);
    step(1'b1, 2'b11, 1'b1, 1'b0, 2'b00);
    repeat (300) rnd_step(1'b1);
    drain();
    step(1'b1, 2'b00, 1'b0, 1'b0, 2'b00);

    @(negedge clk);
    #1;
    check("issue_queue_left", 64'(iss_q.size()), 64'(0));
    check("rsp_queue_left",   64'(rsp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
